window_load_ctrl: RTL and testbench
===================================

WINDOW_LOAD_CTRL -- requirements
Module: window_load_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels; legal range 3..255.
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in pixels; legal range 3..255.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning pixel memory address width.
REQ-004 SHALL have port CLK  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_n  in  1  meaning reset; the reset is synchronous and active-low.
REQ-006 SHALL have port Start  in  1  meaning a one-cycle request to scan one frame.
REQ-007 SHALL have port BaseAddr  in  ADDR_W  meaning the frame base address, latched when Start is accepted.
REQ-008 SHALL have port WindowReady  in  1  meaning the downstream Sobel stage accepts the current window.
REQ-009 SHALL have port MemRead  out  1  meaning a read strobe to the pixel memory, which has a fixed 1-cycle read latency.
REQ-010 SHALL have port MemAddr  out  ADDR_W  meaning the read address.
REQ-011 SHALL have port ShiftEn  out  3  meaning per-row enables for three 3-tap pixel shift registers; bit k loads image row r0+k.
REQ-012 SHALL have port WindowValid  out  1  meaning the 3x3 window held in the shift registers is complete.
REQ-013 SHALL have port OutRow, OutCol  out  8 each  meaning the centre-pixel coordinates of the current window.
REQ-014 SHALL have port Busy  out  1  meaning a scan is in progress, and port Done  out  1  meaning a one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement the states IDLE, READ, WAIT, EMIT and DONE; Busy = (state != IDLE).
REQ-016 SHALL hold internal counters band r0 (0..IMG_H-3), column x (0..IMG_W-1) and sub-row k (0..2).
REQ-017 IDLE: on Start=1, latch BaseAddr, clear r0/x/k, and go to READ; Start SHALL be ignored in every other state.
REQ-018 READ: assert MemRead=1 with MemAddr = BaseAddr + (r0+k)*IMG_W + x, truncated modulo 2^ADDR_W; increment k each cycle; after k=2, go to WAIT.
REQ-019 ShiftEn[k] SHALL be 1 exactly one cycle after the MemRead for sub-row k, and 0 at all other times; at most one bit is set in any cycle.
REQ-020 WAIT lasts one cycle (ShiftEn[2]=1 in it); then go to EMIT if x>=2, else advance.
REQ-021 EMIT: WindowValid=1 with OutRow=r0+1 and OutCol=x-1, both held stable; MemRead=0 and ShiftEn=0 until WindowReady=1 is sampled; then advance.
REQ-022 Advance: if x<IMG_W-1, then x++, k=0 and go to READ; else if r0<IMG_H-3, then r0++, x=0, k=0 and go to READ; else go to DONE.
REQ-023 DONE: Done=1 for exactly one cycle, then go to IDLE.
REQ-024 Unstalled cost SHALL be 4 cycles per column plus 1 cycle per EMIT; the frame emits (IMG_W-2)*(IMG_H-2) windows in raster order.
REQ-025 WindowReady outside EMIT SHALL have no effect.

Reset
REQ-026 RST_n=0 at a clock edge SHALL force IDLE and clear r0/x/k, the latched BaseAddr, MemRead, MemAddr, ShiftEn, WindowValid, OutRow, OutCol, Busy and Done to 0; this applies in any state, including mid-scan.
REQ-027 After reset, the first window SHALL not be flagged until three fresh columns have been loaded; shift-register contents are not cleared.

Verification
REQ-028 Basic scan: IMG_W=4, IMG_H=3, BaseAddr=0x0100, WindowReady=1 -> MemAddr sequence 100,104,108,101,105,109,102,106,10A,103,107,10B; windows (1,1) then (1,2); Busy high 19 cycles; Done at cycle 19.
REQ-029 Backpressure: as REQ-028 but WindowReady=0 for 5 cycles at the first EMIT -> WindowValid high 6 cycles, (1,1) stable, MemRead=0 and ShiftEn=0 throughout.
REQ-030 Multi-band: IMG_W=4, IMG_H=4, BaseAddr=0 -> windows (1,1),(1,2),(2,1),(2,2); the second band starts at MemAddr 0x0004.
REQ-031 Start while Busy: a pulse in READ and in EMIT -> no restart, the address sequence is unchanged, and exactly one Done pulse occurs.
REQ-032 Reset mid-scan: RST_n=0 at EMIT of (1,2) -> all outputs 0 the next cycle; a new Start with BaseAddr=0x0200 rescans from 0x0200 with the first window at (1,1).
REQ-033 Address wrap: ADDR_W=8, BaseAddr=0xFE, IMG_W=4 -> the third MemAddr is 0x06 (truncated modulo 2^8).

Source files
------------

// File: rtl/window_load_ctrl.sv
// Scan controller that feeds a 3x3 Sobel window from a pixel memory with 1-cycle read latency.
// Columns of three pixels are read per band; a window is emitted once three columns are loaded.
//
//   state | meaning
//   IDLE  | waiting for Start
//   READ  | one memory read per cycle for sub-rows k = 0..2 of column x
//   WAIT  | last read data lands in the row-2 shift register
//   EMIT  | window valid, held until WindowReady
//   DONE  | one-cycle end-of-frame pulse
module window_load_ctrl #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic              WindowReady,
   output logic              MemRead,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [2:0]        ShiftEn,
   output logic              WindowValid,
   output logic [7:0]        OutRow,
   output logic [7:0]        OutCol,
   output logic              Busy,
   output logic              Done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_EMIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
   localparam logic [7:0] R_LAST = 8'(IMG_H - 3);

   logic [2:0]        state;
   logic [7:0]        r0;
   logic [7:0]        x;
   logic [1:0]        k;
   logic [ADDR_W-1:0] base_q;
   logic [2:0]        shift_q;

   logic [2:0]        adv_state;
   logic [7:0]        adv_x;
   logic [7:0]        adv_r0;
   logic [31:0]       row_sum;
   logic [31:0]       addr_off;

   // Move to the next column, or to the next band once the row end is reached.
   always_comb begin
      adv_state = S_READ;
      adv_x     = x;
      adv_r0    = r0;
      if (x < X_LAST) begin
         adv_x = x + 8'd1;
      end else if (r0 < R_LAST) begin
         adv_r0 = r0 + 8'd1;
         adv_x  = 8'd0;
      end else begin
         adv_state = S_DONE;
      end
   end

   always_comb begin
      row_sum  = {24'd0, r0} + {30'd0, k};
      addr_off = row_sum * 32'(IMG_W) + {24'd0, x};
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state   <= S_IDLE;
         r0      <= 8'd0;
         x       <= 8'd0;
         k       <= 2'd0;
         base_q  <= '0;
         shift_q <= 3'b000;
      end else begin
         // Read data for sub-row k arrives one cycle after its strobe.
         shift_q <= (state == S_READ) ? 3'(3'b001 << k) : 3'b000;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  base_q <= BaseAddr;
                  r0     <= 8'd0;
                  x      <= 8'd0;
                  k      <= 2'd0;
                  state  <= S_READ;
               end
            end
            S_READ: begin
               if (k == 2'd2) begin
                  state <= S_WAIT;
               end else begin
                  k <= k + 2'd1;
               end
            end
            S_WAIT: begin
               if (x >= 8'd2) begin
                  state <= S_EMIT;
               end else begin
                  state <= adv_state;
                  x     <= adv_x;
                  r0    <= adv_r0;
                  k     <= 2'd0;
               end
            end
            S_EMIT: begin
               if (WindowReady) begin
                  state <= adv_state;
                  x     <= adv_x;
                  r0    <= adv_r0;
                  k     <= 2'd0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      MemRead     = (state == S_READ);
      MemAddr     = MemRead ? base_q + ADDR_W'(addr_off) : '0;
      ShiftEn     = shift_q;
      WindowValid = (state == S_EMIT);
      OutRow      = WindowValid ? r0 + 8'd1 : 8'd0;
      OutCol      = WindowValid ? x - 8'd1 : 8'd0;
      Busy        = (state != S_IDLE);
      Done        = (state == S_DONE);
   end

endmodule

// File: tb/tb_window_load_ctrl.sv
// Directed bench for window_load_ctrl: 4x3 scans (plain, stalled, Start while busy, reset
// mid-scan), a 4x4 two-band scan and an 8-bit address wrap case.
module tb_window_load_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4x3 frame, 16-bit addresses
   logic        a_rst, a_start, a_ready, a_read, a_valid, a_busy, a_done;
   logic [15:0] a_base, a_addr;
   logic [2:0]  a_shift;
   logic [7:0]  a_row, a_col;
   // 4x4 frame, 16-bit addresses
   logic        b_rst, b_start, b_ready, b_read, b_valid, b_busy, b_done;
   logic [15:0] b_base, b_addr;
   logic [2:0]  b_shift;
   logic [7:0]  b_row, b_col;
   // 4x3 frame, 8-bit addresses
   logic        c_rst, c_start, c_ready, c_read, c_valid, c_busy, c_done;
   logic [7:0]  c_base, c_addr;
   logic [2:0]  c_shift;
   logic [7:0]  c_row, c_col;

   window_load_ctrl #(.IMG_W(4), .IMG_H(3), .ADDR_W(16)) dut_a (
      .CLK(clk), .RST_n(a_rst), .Start(a_start), .BaseAddr(a_base), .WindowReady(a_ready),
      .MemRead(a_read), .MemAddr(a_addr), .ShiftEn(a_shift), .WindowValid(a_valid),
      .OutRow(a_row), .OutCol(a_col), .Busy(a_busy), .Done(a_done));

   window_load_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(16)) dut_b (
      .CLK(clk), .RST_n(b_rst), .Start(b_start), .BaseAddr(b_base), .WindowReady(b_ready),
      .MemRead(b_read), .MemAddr(b_addr), .ShiftEn(b_shift), .WindowValid(b_valid),
      .OutRow(b_row), .OutCol(b_col), .Busy(b_busy), .Done(b_done));

   window_load_ctrl #(.IMG_W(4), .IMG_H(3), .ADDR_W(8)) dut_c (
      .CLK(clk), .RST_n(c_rst), .Start(c_start), .BaseAddr(c_base), .WindowReady(c_ready),
      .MemRead(c_read), .MemAddr(c_addr), .ShiftEn(c_shift), .WindowValid(c_valid),
      .OutRow(c_row), .OutCol(c_col), .Busy(c_busy), .Done(c_done));

   // Hand-computed read offsets for a 4-wide, 3-row band: column-major, rows 0..2.
   logic [15:0] offs   [12] = '{16'h0, 16'h4, 16'h8, 16'h1, 16'h5, 16'h9,
                                16'h2, 16'h6, 16'hA, 16'h3, 16'h7, 16'hB};
   logic [7:0]  a_wrow [2]  = '{8'd1, 8'd1};
   logic [7:0]  a_wcol [2]  = '{8'd1, 8'd2};
   logic [7:0]  b_wrow [4]  = '{8'd1, 8'd1, 8'd2, 8'd2};
   logic [7:0]  b_wcol [4]  = '{8'd1, 8'd2, 8'd1, 8'd2};
   logic [7:0]  c_addrs [3] = '{8'hFE, 8'h02, 8'h06};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, "_read"},  32'(a_read),  32'd0);
      chk({tag, "_addr"},  32'(a_addr),  32'd0);
      chk({tag, "_shift"}, 32'(a_shift), 32'd0);
      chk({tag, "_valid"}, 32'(a_valid), 32'd0);
      chk({tag, "_row"},   32'(a_row),   32'd0);
      chk({tag, "_col"},   32'(a_col),   32'd0);
      chk({tag, "_busy"},  32'(a_busy),  32'd0);
      chk({tag, "_done"},  32'(a_done),  32'd0);
   endtask

   // One 4x3 frame on dut_a. stall: cycles of WindowReady=0 at the first window;
   // poke: Start pulses in READ and EMIT; abort: reset at the second window.
   task automatic scan_a(input logic [15:0] base, input int stall, input bit poke, input bit abort);
      int cyc = 1, rd = 0, win = 0, busy_n = 0, done_n = 0, done_cyc = 0, v0 = 0;
      bit prev_read = 1'b0;
      a_base  = base;
      a_start = 1'b1;
      a_ready = 1'b1;
      tick();
      a_start = 1'b0;
      while (cyc < 80) begin
         if (!a_busy && done_n > 0) break;
         a_start = 1'b0;
         a_ready = 1'b1;
         a_base  = base;
         if (a_busy) busy_n++;
         chk("shift_en", 32'(a_shift), prev_read ? (32'd1 << ((rd - 1) % 3)) : 32'd0);
         prev_read = a_read;
         if (a_read) begin
            if (rd < 12) chk("mem_addr", 32'(a_addr), 32'(16'(base + offs[rd])));
            if (poke && rd == 4) begin
               a_start = 1'b1;
               a_base  = 16'h0F00;
            end
            rd++;
         end
         if (a_valid) begin
            chk("emit_no_read", 32'(a_read), 32'd0);
            if (win < 2) begin
               chk("out_row", 32'(a_row), 32'(a_wrow[win]));
               chk("out_col", 32'(a_col), 32'(a_wcol[win]));
            end
            if (abort && win == 1) begin
               a_rst = 1'b0;
               tick();
               chk_a_zero("mid_reset");
               a_rst = 1'b1;
               return;
            end
            if (poke && win == 0 && v0 == 0) begin
               a_start = 1'b1;
               a_base  = 16'h0F00;
            end
            if (win == 0) v0++;
            if (win == 0 && v0 <= stall) a_ready = 1'b0;
            else win++;
         end
         if (a_done) begin
            done_n++;
            done_cyc = cyc;
         end
         tick();
         cyc++;
      end
      if (abort) chk("abort_reached", 32'd0, 32'd1);
      chk("read_count",   32'(rd),       32'd12);
      chk("window_count", 32'(win),      32'd2);
      chk("busy_cycles",  32'(busy_n),   32'(19 + stall));
      chk("done_pulses",  32'(done_n),   32'd1);
      chk("done_cycle",   32'(done_cyc), 32'(19 + stall));
      chk("win0_valid",   32'(v0),       32'(stall + 1));
   endtask

   initial begin
      a_rst = 1'b0; a_start = 1'b0; a_ready = 1'b1; a_base = 16'h0;
      b_rst = 1'b0; b_start = 1'b0; b_ready = 1'b1; b_base = 16'h0;
      c_rst = 1'b0; c_start = 1'b0; c_ready = 1'b1; c_base = 8'h0;
      tick(); tick(); tick();
      chk_a_zero("reset");
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      tick();
      chk("idle_busy", 32'(a_busy), 32'd0);

      scan_a(16'h0100, 0, 1'b0, 1'b0);
      scan_a(16'h0100, 5, 1'b0, 1'b0);
      scan_a(16'h0100, 0, 1'b1, 1'b0);
      scan_a(16'h0100, 0, 1'b0, 1'b1);
      scan_a(16'h0200, 0, 1'b0, 1'b0);

      begin : two_band
         int cyc = 0, rd = 0, win = 0, done_n = 0, busy_n = 0;
         b_base  = 16'h0;
         b_start = 1'b1;
         tick();
         b_start = 1'b0;
         while (cyc < 120) begin
            if (!b_busy && done_n > 0) break;
            if (b_busy) busy_n++;
            if (b_read) begin
               if (rd == 0)  chk("band1_addr", 32'(b_addr), 32'h0);
               if (rd == 12) chk("band2_addr", 32'(b_addr), 32'h4);
               rd++;
            end
            if (b_valid) begin
               if (win < 4) begin
                  chk("b_row", 32'(b_row), 32'(b_wrow[win]));
                  chk("b_col", 32'(b_col), 32'(b_wcol[win]));
               end
               win++;
            end
            if (b_done) done_n++;
            tick();
            cyc++;
         end
         chk("b_reads",   32'(rd),     32'd24);
         chk("b_windows", 32'(win),    32'd4);
         chk("b_done",    32'(done_n), 32'd1);
         chk("b_busy",    32'(busy_n), 32'd37);
      end

      begin : addr_wrap
         int cyc = 0, rd = 0, done_n = 0;
         c_base  = 8'hFE;
         c_start = 1'b1;
         tick();
         c_start = 1'b0;
         while (cyc < 80) begin
            if (!c_busy && done_n > 0) break;
            if (c_read) begin
               if (rd < 3) chk("wrap_addr", 32'(c_addr), 32'(c_addrs[rd]));
               rd++;
            end
            if (c_done) done_n++;
            tick();
            cyc++;
         end
         chk("c_reads", 32'(rd),     32'd12);
         chk("c_done",  32'(done_n), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
